btn_updown_cond: RTL and testbench
==================================

// Module: btn_updown_cond
// PURPOSE
//  Conditions the raw UP/DOWN push-buttons into the single-cycle UP/DOWN strobes consumed by the
//  BCD field registers (year/month/day/hour/min/sec) while a field is being edited.
//  Per button: 2-flop synchronizer, counter debounce, press-edge strobe, hold-to-auto-repeat.
//  The two buttons are mutually exclusive: only one strobe output is ever high in a cycle.
// PARAMETERS
//  DEB_CNT   500_000     cycles a synchronized level must stay constant to be accepted (5 ms @100 MHz)
//  HOLD_CNT  50_000_000  cycles from first strobe to first repeat strobe (500 ms)
//  RPT_CNT   10_000_000  cycles between subsequent repeat strobes (100 ms)
// PORTS
//  CLK       in   1  system clock
//  RST       in   1  synchronous, active-high reset
//  EN        in   1  editing enable (tied to Modificando); low suppresses all strobes
//  BTN_UP    in   1  raw asynchronous button, active-high
//  BTN_DOWN  in   1  raw asynchronous button, active-high
//  UP        out  1  one-cycle increment strobe
//  DOWN      out  1  one-cycle decrement strobe
//  HELD      out  1  high while a button owns the strobe path (IDLE -> 0)
// BEHAVIOUR
//  - Reset: UP=0, DOWN=0, HELD=0; sync flops, debounced levels, counters cleared; FSM=IDLE.
//    A button still held when RST drops is debounced as a fresh press (strobe after latency).
//  - Debounce: cnt clears whenever sync==stable; else increments; at cnt==DEB_CNT-1 stable<=sync.
//  - Latency: raw held from cycle 0 -> strobe high exactly in cycle DEB_CNT+3 (2 sync + DEB_CNT
//    + 1 registered output). Release is debounced identically; glitches < DEB_CNT cycles ignored.
//  - FSM (shared, one owner): IDLE, PRESS, HOLD_WAIT, REPEAT.
//    IDLE: on stable rising edge of a button with EN=1 -> owner<=that button, strobe 1 cycle,
//      go HOLD_WAIT, timer<=0. Same-cycle rising edges on both: UP wins, DOWN ignored.
//    HOLD_WAIT: timer counts; timer==HOLD_CNT-1 -> strobe, timer<=0, go REPEAT.
//    REPEAT: timer==RPT_CNT-1 -> strobe, timer<=0, stay.
//    Any state: owner's stable level falls -> IDLE next cycle, no strobe that cycle.
//    PRESS is the single strobe cycle between IDLE and HOLD_WAIT; HELD=1 in PRESS/HOLD_WAIT/REPEAT.
//  - Non-owner button is ignored while owned; it is not queued. Owner release + non-owner still
//    held -> no strobe; non-owner must be released and re-pressed.
//  - EN=0: UP/DOWN forced 0, FSM -> IDLE, timer cleared; debounce keeps running. EN rising with a
//    button already held produces no strobe (ownership needs a stable rising edge).
//  - Timer width = $clog2(max(HOLD_CNT,RPT_CNT)); debounce cnt width = $clog2(DEB_CNT); no wrap
//    beyond terminal values (cleared on reaching them).
//  - UP and DOWN never both 1; each strobe exactly one cycle wide.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined: HOLD_WAIT/REPEAT behaviour as above.
//  BTN_AUTOREPEAT_EN undefined: exactly one strobe per press; FSM holds in HOLD_WAIT with timer
//    idle until release; HOLD_CNT/RPT_CNT unused; HELD unchanged.
// TESTING  (sim params DEB_CNT=4, HOLD_CNT=20, RPT_CNT=8, BTN_AUTOREPEAT_EN defined, EN=1)
//  1 BTN_UP 0->1 at cycle 0, held 10 cycles -> UP=1 only at cycle 7; DOWN=0 throughout; HELD=1 from 7.
//  2 BTN_UP held 60 cycles -> UP strobes at cycles 7, 27, 35, 43, 51, 59; HELD=0 after release+debounce.
//  3 BTN_DOWN 3-cycle glitches separated by 2 low cycles -> no DOWN strobe, HELD stays 0.
//  4 BTN_UP and BTN_DOWN rise same cycle, held -> only UP strobes; release UP, keep DOWN -> no DOWN strobe.
//  5 BTN_DOWN held, EN=0 at cycle 15 -> no further DOWN; EN=1 at 30 still held -> none until re-press.
//  6 RST=1 at cycle 20 during UP hold (held through) -> outputs 0 in cycle 21; UP strobe 7 cycles
//    after RST drops. Rerun 1 with macro undefined: single UP at 7, none afterwards while held.

Source files
------------

// File: rtl/btn_updown_cond.sv
// Raw UP/DOWN buttons -> debounced, single-owner, one-cycle UP/DOWN edit strobes (optional hold auto-repeat).
// Latency: press to first strobe DEB_CNT+3 cycles; no backpressure, strobes are fire-and-forget.
// Define BTN_AUTOREPEAT_EN for hold-to-repeat; undefined gives exactly one strobe per press.
module btn_updown_cond #(
    parameter int DEB_CNT  = 500_000,
    parameter int HOLD_CNT = 50_000_000,
    parameter int RPT_CNT  = 10_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic BTN_UP,
    input  logic BTN_DOWN,
    output logic UP,
    output logic DOWN,
    output logic HELD
);

    localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int TMAX = (HOLD_CNT > RPT_CNT) ? HOLD_CNT : RPT_CNT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CNT - 1);
    localparam logic [TW-1:0] RPT_LAST  = TW'(RPT_CNT - 1);
    logic [TW-1:0] timer_q, timer_d;
`else
    logic cfg_unused;
    assign cfg_unused = (HOLD_CNT > RPT_CNT);
`endif

    typedef enum logic [1:0] {IDLE, PRESS, HOLD_WAIT, REPEAT} state_t;

    // Bit 0 is the UP button, bit 1 the DOWN button.
    logic [1:0]    s1_q, s1_d, s2_q, s2_d;
    logic [1:0]    stab_q, stab_d, stab_prev_q, stab_prev_d;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   up_q, up_d, down_q, down_d, held_q, held_d;
    logic [1:0] rise;
    logic       own_lvl;

    always_comb begin
        s1_d        = {BTN_DOWN, BTN_UP};
        s2_d        = s1_q;
        stab_prev_d = stab_q;
        stab_d      = stab_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == stab_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEB_LAST) begin
                cnt_d[i]  = '0;
                stab_d[i] = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    assign rise    = stab_q & ~stab_prev_q;
    assign own_lvl = stab_q[owner_q];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        timer_d = timer_q;
`endif
        if (!EN) begin
            state_d = IDLE;
`ifdef BTN_AUTOREPEAT_EN
            timer_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // Simultaneous presses resolve to UP; the loser is dropped, not queued.
                    if (rise[0] || rise[1]) begin
                        owner_d = !rise[0];
                        up_d    = rise[0];
                        down_d  = !rise[0];
                        state_d = PRESS;
`ifdef BTN_AUTOREPEAT_EN
                        timer_d = '0;
`endif
                    end
                end
                PRESS: begin
                    if (!own_lvl) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD_WAIT;
`ifdef BTN_AUTOREPEAT_EN
                        timer_d = timer_q + 1'b1;
`endif
                    end
                end
                HOLD_WAIT, REPEAT: begin
                    if (!own_lvl) begin
                        state_d = IDLE;
`ifdef BTN_AUTOREPEAT_EN
                        timer_d = '0;
                    end else if ((state_q == HOLD_WAIT && timer_q == HOLD_LAST) ||
                                 (state_q == REPEAT && timer_q == RPT_LAST)) begin
                        up_d    = !owner_q;
                        down_d  = owner_q;
                        timer_d = '0;
                        state_d = REPEAT;
                    end else begin
                        timer_d = timer_q + 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        held_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q        <= '0;
            s2_q        <= '0;
            stab_q      <= '0;
            stab_prev_q <= '0;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            held_q      <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            timer_q     <= '0;
`endif
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            stab_q      <= stab_d;
            stab_prev_q <= stab_prev_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            state_q     <= state_d;
            owner_q     <= owner_d;
            up_q        <= up_d;
            down_q      <= down_d;
            held_q      <= held_d;
`ifdef BTN_AUTOREPEAT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign UP   = up_q;
    assign DOWN = down_q;
    assign HELD = held_q;

endmodule

// File: tb/tb_btn_updown_cond.sv
// Directed bench for btn_updown_cond with DEB_CNT=4, HOLD_CNT=20, RPT_CNT=8.
// Expectations follow BTN_AUTOREPEAT_EN as seen by this compile.
module tb_btn_updown_cond;

    logic clk = 1'b0;
    logic rst, en, btn_up, btn_down;
    logic up, down, held;

    int checks = 0;
    int errors = 0;
    int both_hi;
    logic [127:0] obs_up, obs_down, obs_held;
    logic [127:0] exp_up, exp_down, exp_held;

    always #5 clk = ~clk;

    btn_updown_cond #(.DEB_CNT(4), .HOLD_CNT(20), .RPT_CNT(8)) dut (
        .CLK(clk), .RST(rst), .EN(en), .BTN_UP(btn_up), .BTN_DOWN(btn_down),
        .UP(up), .DOWN(down), .HELD(held)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rng(input int lo, input int hi);
        logic [127:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [127:0] at(input int b);
        logic [127:0] m = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Cycle c: inputs applied just after edge c-1, outputs sampled mid-cycle.
    task automatic run(input int tid, input int n);
        obs_up = '0; obs_down = '0; obs_held = '0;
        for (int c = 0; c < n; c++) begin
            btn_up = 1'b0; btn_down = 1'b0; en = 1'b1; rst = 1'b0;
            case (tid)
                1: btn_up = (c < 10);
                2: btn_up = (c < 60);
                3: btn_down = (c < 40) && ((c % 5) < 3);
                4: begin btn_up = (c < 30); btn_down = (c < 50); end
                5: begin btn_down = (c < 60) || (c >= 70); en = !(c >= 15 && c < 30); end
                6: begin btn_up = (c < 60); rst = (c == 20); end
                default: ;
            endcase
            @(negedge clk);
            obs_up[c] = up; obs_down[c] = down; obs_held[c] = held;
            if (up && down) both_hi++;
            @(posedge clk);
            #1;
        end
        btn_up = 1'b0; btn_down = 1'b0; en = 1'b1; rst = 1'b0;
    endtask

    task automatic score(input string name);
        check({name, "_up"}, obs_up, exp_up);
        check({name, "_down"}, obs_down, exp_down);
        check({name, "_held"}, obs_held, exp_held);
    endtask

    initial begin
        both_hi = 0;
        do_reset();
        @(negedge clk);
        check("reset_outs", {125'd0, up, down, held}, 128'd0);
        @(posedge clk);
        #1;

        // Single press, short hold.
        do_reset(); run(1, 25);
        exp_up = at(7); exp_down = '0; exp_held = rng(7, 16);
        score("t1");

        // Long hold.
        do_reset(); run(2, 75);
`ifdef BTN_AUTOREPEAT_EN
        exp_up = at(7) | at(27) | at(35) | at(43) | at(51) | at(59);
`else
        exp_up = at(7);
`endif
        exp_down = '0; exp_held = rng(7, 66);
        score("t2");

        // Glitches shorter than the debounce window.
        do_reset(); run(3, 50);
        exp_up = '0; exp_down = '0; exp_held = '0;
        score("t3");

        // Simultaneous press, then UP released while DOWN held.
        do_reset(); run(4, 60);
`ifdef BTN_AUTOREPEAT_EN
        exp_up = at(7) | at(27) | at(35);
`else
        exp_up = at(7);
`endif
        exp_down = '0; exp_held = rng(7, 36);
        score("t4");

        // EN dropped mid-hold, restored while held, then re-press.
        do_reset(); run(5, 85);
        exp_up = '0; exp_down = at(7) | at(77); exp_held = rng(7, 15) | rng(77, 84);
        score("t5");

        // Reset pulse during a hold.
        do_reset(); run(6, 45);
        exp_up = at(7) | at(28); exp_down = '0; exp_held = rng(7, 20) | rng(28, 44);
        score("t6");

        check("up_down_exclusive", 128'(both_hi), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
